// File: rtl/feed_scheduler.sv
// Task dispatcher / result gatherer for WORKERS feed cores: one task in flight per
// core, round-robin refill of idle cores and round-robin collection of results.

module feed_scheduler_lane (
  input  logic clock,
  input  logic reset,
  input  logic set,
  input  logic clr,
  input  logic res_valid,
  input  logic in_dispatch,
  output logic busy,
  output logic eligible,
  output logic stray
);
  // set (dispatch) only hits an idle lane and clr (grant) only a busy one
  always_ff @(posedge clock or negedge reset)
    if (!reset)   busy <= 1'b0;
    else if (set) busy <= 1'b1;
    else if (clr) busy <= 1'b0;

  assign eligible = res_valid & busy & ~in_dispatch;
  assign stray    = res_valid & ~busy;
endmodule

module feed_scheduler #(
  parameter int WORKERS = 4,
  parameter int IN_W    = 144,
  parameter int OUT_W   = 40,
  parameter int WID_W   = $clog2(WORKERS)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [IN_W-1:0]          input_data,
  input  logic                     input_valid,
  output logic                     input_ready,
  output logic [IN_W-1:0]          w_in_data,
  output logic [WORKERS-1:0]       w_in_valid,
  input  logic [WORKERS-1:0]       w_in_ready,
  input  logic [WORKERS*OUT_W-1:0] w_out_data,
  input  logic [WORKERS-1:0]       w_out_valid,
  output logic [WORKERS-1:0]       w_out_ready,
  output logic [OUT_W-1:0]         output_data,
  output logic [WID_W-1:0]         output_worker,
  output logic                     output_valid,
  input  logic                     output_ready,
  output logic [WORKERS-1:0]       busy,
  output logic                     idle,
  output logic                     proto_err,
  output logic [31:0]              dispatched
);
  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic [WID_W-1:0] wid;
  } res_t;

  // first requesting index at or after ptr, wrapping
  function automatic logic [WID_W-1:0] rr_pick(input logic [WORKERS-1:0] req,
                                               input logic [WID_W-1:0]   ptr);
    logic [WID_W-1:0] sel;
    logic [WID_W:0]   sum;
    logic             found;
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < WORKERS; k++) begin
      sum = {1'b0, ptr} + (WID_W+1)'(k);
      if (sum >= (WID_W+1)'(WORKERS)) sum = sum - (WID_W+1)'(WORKERS);
      if (!found && req[sum[WID_W-1:0]]) begin
        found = 1'b1;
        sel   = sum[WID_W-1:0];
      end
    end
    return sel;
  endfunction

  function automatic logic [WID_W-1:0] ptr_next(input logic [WID_W-1:0] p);
    return (p == WID_W'(WORKERS-1)) ? '0 : p + 1'b1;
  endfunction

  logic                          pend;
  logic [WORKERS-1:0]            tgt;
  logic [WID_W-1:0]              d_ptr, g_ptr, d_sel, g_sel;
  logic [WORKERS-1:0]            d_oh, g_oh, eligible, stray, lane_set;
  logic [WORKERS-1:0][OUT_W-1:0] lane_data;
  logic                          accept, load, grant;
  res_t                          res_q;

  assign lane_data   = w_out_data;
  assign input_ready = !pend && (|(~busy));
  assign accept      = input_valid && input_ready;
  assign w_in_valid  = pend ? tgt : '0;
  assign d_sel       = rr_pick(~busy, d_ptr);
  assign g_sel       = rr_pick(eligible, g_ptr);
  assign load        = !output_valid || output_ready;
  assign grant       = load && (|eligible);
  assign w_out_ready = grant ? g_oh : '0;
  assign lane_set    = accept ? d_oh : '0;

  genvar i;
  generate
    for (i = 0; i < WORKERS; i++) begin : g_lane
      assign d_oh[i] = (d_sel == WID_W'(i));
      assign g_oh[i] = (g_sel == WID_W'(i));
      feed_scheduler_lane u_lane (
        .clock       (clock),
        .reset       (reset),
        .set         (lane_set[i]),
        .clr         (w_out_ready[i]),
        .res_valid   (w_out_valid[i]),
        .in_dispatch (pend & tgt[i]),
        .busy        (busy[i]),
        .eligible    (eligible[i]),
        .stray       (stray[i])
      );
    end
  endgenerate

  // dispatch register; payload and target hold until the worker takes it
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      pend       <= 1'b0;
      tgt        <= '0;
      w_in_data  <= '0;
      d_ptr      <= '0;
      dispatched <= '0;
    end else if (accept) begin
      pend       <= 1'b1;
      tgt        <= d_oh;
      w_in_data  <= input_data;
      d_ptr      <= ptr_next(d_sel);
      dispatched <= dispatched + 32'd1;
    end else if (|(w_in_valid & w_in_ready)) begin
      pend       <= 1'b0;
    end

  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      output_valid <= 1'b0;
      res_q        <= '0;
      g_ptr        <= '0;
    end else if (load) begin
      output_valid <= grant;
      if (grant) begin
        res_q.data <= lane_data[g_sel];
        res_q.wid  <= g_sel;
        g_ptr      <= ptr_next(g_sel);
      end
    end

  always_ff @(posedge clock or negedge reset)
    if (!reset) proto_err <= 1'b0;
    else        proto_err <= proto_err | (|stray);

  assign output_data   = res_q.data;
  assign output_worker = res_q.wid;
  assign idle          = !pend && (busy == '0) && !output_valid;
endmodule
